// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - shared widths, default thresholds and event type for the spike monitor
package izh_pkg;
  localparam int V_W = 8;
  localparam int ISI_W = 16;
  localparam logic signed [V_W-1:0] THRESH_DEF = 8'sd30;
  localparam int BURST_ISI_DEF = 64;

  typedef struct packed {
    logic             burst;
    logic [ISI_W-1:0] isi;
  } izh_evt_t;
endpackage

// File: rtl/izh_event_fifo.sv
// rtl/izh_event_fifo.sv - first-word-fall-through event queue with wrap-bit pointers
module izh_event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [16:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/izh_spike_monitor.sv
// rtl/izh_spike_monitor.sv - threshold-crossing spike detector with ISI measurement,
// burst classification and a queued event readout.
module izh_spike_monitor
  import izh_pkg::*;
#(
  parameter logic signed [7:0] THRESH    = THRESH_DEF,
  parameter int                BURST_ISI = BURST_ISI_DEF,
  parameter int                DEPTH     = 4,
  parameter int                ISI_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       v_in,
  output logic             spike_o,
  output logic [7:0]       spike_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ISI_W:0]   evt_data,
  output logic             overflow
);
  typedef struct packed {
    logic             burst;
    logic [ISI_W-1:0] isi;
  } evt_t;

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic [7:0]       r_v_q;
  logic [ISI_W-1:0] r_isi_cnt;
  logic             r_seen;
  logic             w_spike_det;
  logic [ISI_W-1:0] w_isi_inc;
  logic [ISI_W-1:0] w_isi_cap;
  evt_t             w_evt;
  evt_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_spike_det = ena && ($signed(v_in) > THRESH) && !($signed(r_v_q) > THRESH);
  assign w_isi_inc   = (r_isi_cnt == ISI_MAX) ? ISI_MAX : r_isi_cnt + ISI_W'(1);
  // The first spike has no predecessor, so it reports a zero interval and no burst.
  assign w_isi_cap   = r_seen ? w_isi_inc : '0;
  assign w_evt.isi   = w_isi_cap;
  assign w_evt.burst = r_seen && (32'(w_isi_cap) <= BURST_ISI);

  assign evt_valid = !w_empty;
  assign w_pop     = !w_empty && evt_ready;
  assign w_push    = w_spike_det && (!w_full || w_pop);
  assign evt_data  = w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_q       <= '0;
      r_isi_cnt   <= '0;
      r_seen      <= 1'b0;
      spike_o     <= 1'b0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      spike_o <= w_spike_det;
      if (ena) begin
        r_v_q     <= v_in;
        r_isi_cnt <= w_spike_det ? '0 : w_isi_inc;
      end
      if (w_spike_det) begin
        r_seen      <= 1'b1;
        spike_count <= spike_count + 8'd1;
        if (w_full && !w_pop) overflow <= 1'b1;
      end
    end
  end

  izh_event_fifo #(
    .DEPTH(DEPTH),
    .T    (evt_t)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_evt),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule
